db_feed_launcher: RTL and testbench



---
 rtl/db_feed_launcher.sv | 128 ++++++++++++
 tb/tb_db_feed_launcher.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/db_feed_launcher.sv
// Feeds a valid/ready word stream into one half of a double-buffered summing component
// and launches the component on each half as soon as that half is full.
module db_feed_launcher #(
  parameter int unsigned ARRAY_SIZE = 256,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 9
) (
  input  logic              clk,
  input  logic              reset,

  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,

  output logic              avs_a_write,
  output logic [DATA_W-1:0] avs_a_writedata,
  output logic [ADDR_W-1:0] avs_a_address,
  output logic [3:0]        avs_a_byteenable,

  output logic              call_valid,
  input  logic              call_stall,
  output logic              db_data,

  input  logic              return_valid,
  output logic              return_stall,
  input  logic [DATA_W-1:0] returndata_data,

  output logic              result_valid,
  output logic [DATA_W-1:0] result_data,
  input  logic              result_ready
);

  localparam int unsigned CntW = $clog2(ARRAY_SIZE);

  typedef enum logic [1:0] {StIdle, StCall, StBusy} state_e;

  state_e          state_q;
  logic            fill_half_q;
  logic [CntW-1:0] wcount_q;
  logic [1:0]      full_q, full_d;
  logic            call_half_q;

  logic accept, fill_done, ret_accept;

  assign in_ready         = ~full_q[fill_half_q];
  assign accept           = in_valid & in_ready;
  assign fill_done        = accept & (wcount_q == CntW'(ARRAY_SIZE - 1));
  // A result is only taken when the one-entry result register is empty.
  assign ret_accept       = (state_q == StBusy) & return_valid & ~result_valid;
  assign return_stall     = result_valid;
  assign avs_a_byteenable = 4'b1111;

  // Fill and return never touch the same half in one cycle, so both updates apply.
  always_comb begin
    full_d = full_q;
    if (ret_accept) full_d[call_half_q] = 1'b0;
    if (fill_done)  full_d[fill_half_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fill_half_q     <= 1'b0;
      wcount_q        <= '0;
      full_q          <= 2'b00;
      avs_a_write     <= 1'b0;
      avs_a_address   <= '0;
      avs_a_writedata <= '0;
    end else begin
      full_q      <= full_d;
      avs_a_write <= accept;
      if (accept) begin
        avs_a_address   <= ADDR_W'({fill_half_q, wcount_q});
        avs_a_writedata <= in_data;
        wcount_q        <= wcount_q + CntW'(1);
        if (fill_done) fill_half_q <= ~fill_half_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      call_valid  <= 1'b0;
      db_data     <= 1'b0;
      call_half_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (full_q[call_half_q]) begin
            call_valid <= 1'b1;
            db_data    <= call_half_q;
            state_q    <= StCall;
          end
        end
        StCall: begin
          if (!call_stall) begin
            call_valid <= 1'b0;
            state_q    <= StBusy;
          end
        end
        StBusy: begin
          db_data <= call_half_q;
          if (ret_accept) begin
            call_half_q <= ~call_half_q;
            state_q     <= StIdle;
          end
        end
        default: begin
          call_valid <= 1'b0;
          state_q    <= StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result_valid <= 1'b0;
      result_data  <= '0;
    end else if (ret_accept) begin
      result_valid <= 1'b1;
      result_data  <= returndata_data;
    end else if (result_valid && result_ready) begin
      result_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_db_feed_launcher.sv
// Bench for db_feed_launcher: acts as upstream, component and downstream, and checks
// every write, call, back-pressure cycle and result against a word-level model.
module tb_db_feed_launcher;

  localparam int unsigned AS = 256;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 9;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          avs_a_write;
  logic [DW-1:0] avs_a_writedata;
  logic [AW-1:0] avs_a_address;
  logic [3:0]    avs_a_byteenable;
  logic          call_valid;
  logic          call_stall = 1'b0;
  logic          db_data;
  logic          return_valid = 1'b0;
  logic          return_stall;
  logic [DW-1:0] returndata_data = '0;
  logic          result_valid;
  logic [DW-1:0] result_data;
  logic          result_ready = 1'b0;

  db_feed_launcher #(.ARRAY_SIZE(AS), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk             (clk),
    .reset           (reset),
    .in_data         (in_data),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .avs_a_write     (avs_a_write),
    .avs_a_writedata (avs_a_writedata),
    .avs_a_address   (avs_a_address),
    .avs_a_byteenable(avs_a_byteenable),
    .call_valid      (call_valid),
    .call_stall      (call_stall),
    .db_data         (db_data),
    .return_valid    (return_valid),
    .return_stall    (return_stall),
    .returndata_data (returndata_data),
    .result_valid    (result_valid),
    .result_data     (result_data),
    .result_ready    (result_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Knobs set by the main sequence on rising edges, read by the agent on falling edges.
  int rst_cycles  = 3;
  int valid_pct   = 100;
  int cs_mode     = 0;
  int rr_mode     = 1;
  bit no_return   = 1'b0;
  int stall_first = 0;
  int max_delay   = 3;

  logic [DW-1:0] feed_q[$];
  logic [DW-1:0] got_q[$];
  int            call_db_q[$];
  int            wr_addr_q[$];
  int            lat_q[$];

  // Word-level model: k-th accepted word goes to address k mod 2*AS; every AS words form a sum.
  int            exp_wr_addr[$];
  logic [DW-1:0] exp_wr_data[$];
  logic [DW-1:0] exp_res[$];
  logic [DW-1:0] part_sum;
  int            acc_n, done_halves, ret_halves, calls_n, cv_cycles, last_done_cyc, cyc;
  bit            cv_prev, chk_rst_next;

  logic [DW-1:0] mem [0:2*AS-1];
  bit            comp_busy;
  int            comp_delay;
  logic [DW-1:0] comp_sum;

  // Agent: observes this cycle's outputs, drives this cycle's inputs, then books the
  // handshakes that the coming rising edge will complete.
  initial begin
    logic [DW-1:0] w;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_cycles > 0) begin
        reset        = 1'b1;
        rst_cycles--;
        in_valid     = 1'b0;
        call_stall   = 1'b0;
        return_valid = 1'b0;
        result_ready = 1'b0;
        exp_wr_addr.delete(); exp_wr_data.delete(); exp_res.delete();
        got_q.delete(); call_db_q.delete(); wr_addr_q.delete(); lat_q.delete();
        part_sum = '0; acc_n = 0; done_halves = 0; ret_halves = 0; calls_n = 0;
        cv_cycles = 0; cv_prev = 1'b0; comp_busy = 1'b0;
        chk_rst_next = (rst_cycles == 0);
      end else begin
        reset = 1'b0;
        if (chk_rst_next) begin
          chk_rst_next = 1'b0;
          chk("reset in_ready", in_ready, 1);
          chk("reset avs_a_write", avs_a_write, 0);
          chk("reset avs_a_address", avs_a_address, 0);
          chk("reset avs_a_writedata", avs_a_writedata, 0);
          chk("reset avs_a_byteenable", avs_a_byteenable, 15);
          chk("reset call_valid", call_valid, 0);
          chk("reset db_data", db_data, 0);
          chk("reset return_stall", return_stall, 0);
          chk("reset result_valid", result_valid, 0);
          chk("reset result_data", result_data, 0);
        end
        if (avs_a_write) begin
          mem[avs_a_address] = avs_a_writedata;
          wr_addr_q.push_back(int'(avs_a_address));
          if (exp_wr_addr.size() == 0) chk("unexpected write", 1, 0);
          else begin
            chk("write address", avs_a_address, exp_wr_addr.pop_front());
            chk("write data", avs_a_writedata, exp_wr_data.pop_front());
          end
        end
        chk("in_ready", in_ready, (done_halves - ret_halves) < 2);
        if (call_valid) begin
          cv_cycles++;
          chk("call db_data", db_data, calls_n % 2);
          if (!cv_prev) lat_q.push_back(cyc - last_done_cyc);
        end
        cv_prev = call_valid;

        in_valid = (feed_q.size() > 0) && (int'($urandom_range(99)) < valid_pct);
        in_data  = in_valid ? feed_q[0] : '0;
        if (call_valid && stall_first > 0) begin
          call_stall = 1'b1;
          stall_first--;
        end else begin
          call_stall = (cs_mode == 1) ? 1'($urandom_range(1)) : 1'b0;
        end
        return_valid = 1'b0;
        if (comp_busy && !no_return) begin
          if (comp_delay > 0) comp_delay--;
          else begin
            return_valid    = 1'b1;
            returndata_data = comp_sum;
          end
        end
        result_ready = (rr_mode == 0) ? 1'b0 : (rr_mode == 1) ? 1'b1 : 1'($urandom_range(1));

        if (in_valid && in_ready) begin
          w = feed_q.pop_front();
          exp_wr_addr.push_back(acc_n % (2 * AS));
          exp_wr_data.push_back(w);
          part_sum += w;
          acc_n++;
          if (acc_n % AS == 0) begin
            exp_res.push_back(part_sum);
            part_sum      = '0;
            done_halves++;
            last_done_cyc = cyc;
          end
        end
        if (call_valid && !call_stall) begin
          call_db_q.push_back(int'(db_data));
          calls_n++;
          comp_busy  = 1'b1;
          comp_delay = int'($urandom_range(max_delay));
          comp_sum   = '0;
          for (int a = 0; a < AS; a++) comp_sum += mem[int'(db_data) * AS + a];
        end
        if (return_valid && !return_stall) begin
          comp_busy = 1'b0;
          ret_halves++;
        end
        if (result_valid && result_ready) begin
          got_q.push_back(result_data);
          if (exp_res.size() == 0) chk("unexpected result", 1, 0);
          else chk("result in order", result_data, exp_res.pop_front());
        end
      end
    end
  end

  task automatic do_reset(input int n);
    @(posedge clk);
    feed_q.delete();
    rst_cycles = n;
    repeat (n + 2) @(posedge clk);
  endtask

  task automatic wait_results(input int n, input int budget, input string name);
    while (got_q.size() < n && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    chk({name, " result count"}, got_q.size(), n);
  endtask

  typedef struct {
    int unsigned   first;
    int unsigned   addr0;
    int unsigned   db;
    logic [DW-1:0] sum;
    int unsigned   lat;
  } vec_t;

  vec_t          tbl [4];
  logic [DW-1:0] words [1024];
  logic [DW-1:0] sums [4];
  int            max_addr;

  initial begin
    tbl[0] = '{first: 0,   addr0: 0,   db: 0, sum: 32'd32640,  lat: 2};
    tbl[1] = '{first: 256, addr0: 256, db: 1, sum: 32'd98176,  lat: 2};
    tbl[2] = '{first: 512, addr0: 0,   db: 0, sum: 32'd163712, lat: 2};
    tbl[3] = '{first: 768, addr0: 256, db: 1, sum: 32'd229248, lat: 2};

    repeat (6) @(posedge clk);

    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < AS; k++) feed_q.push_back(DW'(tbl[i].first + k));
      wait_results(i + 1, 1500, "table");
      if (got_q.size() > i) chk("table sum", got_q[i], tbl[i].sum);
      if (call_db_q.size() > i) chk("table db_data", call_db_q[i], tbl[i].db);
      if (wr_addr_q.size() >= (i + 1) * AS) begin
        chk("table first addr", wr_addr_q[i * AS], tbl[i].addr0);
        chk("table last addr", wr_addr_q[i * AS + AS - 1], tbl[i].addr0 + AS - 1);
      end
      if (lat_q.size() > i) chk("table launch latency", lat_q[i], tbl[i].lat);
    end

    // Held call_stall at the first launch.
    do_reset(1);
    stall_first = 5;
    for (int k = 0; k < AS; k++) feed_q.push_back(DW'(k));
    wait_results(1, 1500, "stall");
    chk("stall call_valid cycles", cv_cycles, 6);
    chk("stall calls accepted", calls_n, 1);
    if (got_q.size() > 0) chk("stall sum", got_q[0], 32640);

    // Component never returns: both halves fill, then back-pressure.
    do_reset(1);
    no_return = 1'b1;
    for (int k = 0; k < 600; k++) feed_q.push_back(DW'(k));
    repeat (800) @(posedge clk);
    max_addr = -1;
    foreach (wr_addr_q[j]) if (wr_addr_q[j] > max_addr) max_addr = wr_addr_q[j];
    chk("noret accepted", acc_n, 512);
    chk("noret writes", wr_addr_q.size(), 512);
    chk("noret max addr", max_addr, 511);
    chk("noret in_ready", in_ready, 0);
    chk("noret words left", feed_q.size(), 88);
    chk("noret calls", calls_n, 1);
    do_reset(1);
    no_return = 1'b0;

    // Downstream holds off after the first result.
    rr_mode = 0;
    for (int k = 0; k < 2 * AS; k++) feed_q.push_back(DW'(k));
    repeat (700) @(posedge clk);
    chk("hold result_valid", result_valid, 1);
    chk("hold result_data", result_data, 32640);
    chk("hold return_stall", return_stall, 1);
    chk("hold return_valid", return_valid, 1);
    chk("hold returns taken", ret_halves, 1);
    chk("hold in_ready", in_ready, 1);
    rr_mode = 1;
    wait_results(2, 200, "hold");
    if (got_q.size() > 1) begin
      chk("hold first", got_q[0], 32640);
      chk("hold second", got_q[1], 98176);
    end

    // Reset after 100 accepted words.
    do_reset(1);
    for (int k = 0; k < 100; k++) feed_q.push_back(DW'(1000 + k));
    repeat (150) @(posedge clk);
    chk("midreset accepted", acc_n, 100);
    do_reset(1);
    feed_q.push_back(DW'(777));
    repeat (5) @(posedge clk);
    chk("midreset write count", wr_addr_q.size(), 1);
    if (wr_addr_q.size() > 0) chk("midreset first addr", wr_addr_q[0], 0);

    // Random traffic on every handshake.
    do_reset(1);
    valid_pct = 50;
    cs_mode   = 1;
    rr_mode   = 2;
    max_delay = 8;
    for (int j = 0; j < 4; j++) sums[j] = '0;
    for (int k = 0; k < 1024; k++) begin
      words[k] = $urandom;
      sums[k / AS] += words[k];
      feed_q.push_back(words[k]);
    end
    wait_results(4, 20000, "random");
    for (int j = 0; j < 4; j++)
      if (got_q.size() > j) chk("random half sum", got_q[j], sums[j]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
